// File: rtl/sharpe_uart_rx_if.sv
// Pair handshake between the UART receiver and the downstream comparator.
interface sharpe_pair_if;
  logic [7:0] sharpe_old;
  logic [7:0] sharpe_new;
  logic       pair_valid;
  logic       pair_ready;

  modport master (output sharpe_old, output sharpe_new, output pair_valid, input  pair_ready);
  modport slave  (input  sharpe_old, input  sharpe_new, input  pair_valid, output pair_ready);
endinterface

// File: rtl/sharpe_uart_rx.sv
// 8N1 UART receiver that collects bytes in pairs (old, new) and presents
// them on a valid/ready handshake, flagging framing errors and dropped bytes.
module sharpe_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  sharpe_pair_if.master pair,
  output logic          frame_err,
  output logic          overrun
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [2:0]      r_idx,   w_idx_nxt;
  logic [7:0]      r_data,  w_data_nxt;
  logic            w_commit, w_ferr;
  logic            r_rx_meta, r_rx_s;

  logic            r_slot;
  logic [7:0]      r_hold, r_old, r_new;
  logic            r_valid, r_frame_err, r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (!r_rx_s) w_state_nxt = START;
      end
      START: begin
        // mid-start-bit recheck rejects glitches shorter than half a bit
        if (r_timer == T_HALF) begin
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      DATA: begin
        if (r_timer == T_LAST) begin
          w_timer_nxt        = '0;
          w_data_nxt[r_idx]  = r_rx_s;
          if (r_idx == 3'd7) w_state_nxt = STOP;
          else               w_idx_nxt   = r_idx + 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      STOP: begin
        if (r_timer == T_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = IDLE;
          w_commit    = r_rx_s;
          w_ferr      = !r_rx_s;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= 1'b0;
      r_hold      <= '0;
      r_old       <= '0;
      r_new       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (r_valid && pair.pair_ready) r_valid <= 1'b0;
      if (w_ferr) begin
        r_slot <= 1'b0;
      end else if (w_commit) begin
        if (!r_slot) begin
          r_hold <= r_data;
          r_slot <= 1'b1;
        end else begin
          r_slot <= 1'b0;
          // a same-cycle handshake frees the output, so the new pair may load
          if (!r_valid || pair.pair_ready) begin
            r_old   <= r_hold;
            r_new   <= r_data;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign pair.sharpe_old = r_old;
  assign pair.sharpe_new = r_new;
  assign pair.pair_valid = r_valid;
  assign frame_err       = r_frame_err;
  assign overrun         = r_overrun;
endmodule

// File: tb/tb_sharpe_uart_rx.sv
// Directed and random frames checked against a transaction-level pair model.
module tb_sharpe_uart_rx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun;

  sharpe_pair_if pif();

  sharpe_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .pair(pif.master),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int acc_cnt = 0, ferr_cnt = 0;

  // observed handshakes and frame-error pulses
  always @(posedge clk) begin
    if (rst_n && pif.pair_valid && pif.pair_ready) acc_cnt++;
    if (rst_n && frame_err) ferr_cnt++;
  end

  // reference model state
  bit         m_slot, m_valid, m_ovr;
  logic [7:0] m_hold, m_old, m_new;
  int         m_acc = 0, m_ferr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".old"},   pif.sharpe_old, m_old);
    check({tag, ".new"},   pif.sharpe_new, m_new);
    check({tag, ".valid"}, pif.pair_valid, m_valid);
    check({tag, ".ovr"},   overrun,        m_ovr);
    check({tag, ".ferr"},  ferr_cnt,       m_ferr);
    check({tag, ".acc"},   acc_cnt,        m_acc);
  endtask

  task automatic model_reset();
    m_slot = 0; m_valid = 0; m_ovr = 0;
    m_hold = 8'h00; m_old = 8'h00; m_new = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr++;
      m_slot = 0;
    end else if (!m_slot) begin
      m_hold = b;
      m_slot = 1;
    end else begin
      m_slot = 0;
      if (!m_valid || pif.pair_ready) begin
        if (m_valid) m_acc++;
        m_old = m_hold; m_new = b; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic model_settle();
    if (pif.pair_ready && m_valid) begin
      m_acc++;
      m_valid = 0;
    end
  endtask

  task automatic set_ready(input bit v);
    pif.pair_ready = v;
    model_settle();
  endtask

  // returns at the negedge inside the stop-bit sample cycle
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit rdy_at_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    if (rdy_at_stop) pif.pair_ready = 1'b1;
    rx = 1'b1;
  endtask

  task automatic gap();
    rx = 1'b1;
    repeat (CPB + 3) @(negedge clk);
    model_settle();
  endtask

  task automatic frame(input logic [7:0] b, input bit ok);
    send_frame(b, ok, 1'b0);
    model_frame(b, ok);
    gap();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    bit rok, rr;
    pif.pair_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.old", pif.sharpe_old, 8'h00);
    check("rst.new", pif.sharpe_new, 8'h00);
    check("rst.valid", pif.pair_valid, 1'b0);
    check("rst.ferr", frame_err, 1'b0);
    check("rst.ovr", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic pair with latency and single-cycle valid
    set_ready(1'b1);
    frame(8'h7B, 1'b1);
    check_all("p1a");
    send_frame(8'h80, 1'b1, 1'b0);
    model_frame(8'h80, 1'b1);
    check("lat.pre", pif.pair_valid, 1'b0);
    @(negedge clk);
    check("lat.rise", pif.pair_valid, 1'b1);
    check("lat.old", pif.sharpe_old, 8'h7B);
    check("lat.new", pif.sharpe_new, 8'h80);
    @(negedge clk);
    check("lat.fall", pif.pair_valid, 1'b0);
    gap();
    check_all("p1b");

    // one-clock glitch on rx
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch.ferr", frame_err, 1'b0);
    check_all("glitch");

    // frame error resets the slot pointer
    frame(8'h33, 1'b1);
    frame(8'h55, 1'b0);
    check_all("ferr");
    frame(8'h10, 1'b1);
    frame(8'h20, 1'b1);
    check_all("ferr.pair");

    // backpressure and overrun
    set_ready(1'b0);
    frame(8'h01, 1'b1);
    frame(8'h02, 1'b1);
    frame(8'h03, 1'b1);
    frame(8'h04, 1'b1);
    check_all("ovr");
    set_ready(1'b1);
    @(negedge clk);
    check("ovr.drain", pif.pair_valid, 1'b0);
    check_all("ovr.after");

    // reset in the middle of the second byte
    frame(8'hC3, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h5A >> i);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_all("midrst");
    check("midrst.ferr", frame_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gap();
    frame(8'hAA, 1'b1);
    frame(8'hBB, 1'b1);
    check_all("midrst.pair");

    // handshake in the same cycle as a second-byte commit
    set_ready(1'b0);
    frame(8'h11, 1'b1);
    frame(8'h22, 1'b1);
    check_all("same.hold");
    frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1, 1'b1);
    model_frame(8'h44, 1'b1);
    @(negedge clk);
    check("same.valid", pif.pair_valid, 1'b1);
    check("same.old", pif.sharpe_old, 8'h33);
    check("same.new", pif.sharpe_new, 8'h44);
    check("same.ovr", overrun, 1'b0);
    check("same.acc", acc_cnt, m_acc);
    gap();
    check_all("same.after");

    // random traffic
    for (int k = 0; k < 16; k++) begin
      rr  = 1'($urandom_range(0, 1));
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 5) != 0);
      set_ready(rr);
      frame(rb, rok);
      check_all($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sharpe_uart_rx.md
SHARPE_UART_RX -- requirements
Module: sharpe_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range is 4 or more.
REQ-002 Port clk, input, 1, meaning single system clock; all logic is rising-edge.
REQ-003 Port rst_n, input, 1, meaning reset, asynchronous assert, active-low.
REQ-004 Port rx, input, 1, meaning UART serial line, idle high, asynchronous to clk.
REQ-005 Port sharpe_old, output, 8, meaning first byte of the received pair.
REQ-006 Port sharpe_new, output, 8, meaning second byte of the received pair.
REQ-007 Port pair_valid, output, 1, meaning sharpe_old/sharpe_new hold a complete pair.
REQ-008 Port pair_ready, input, 1, meaning the downstream comparator accepts the pair.
REQ-009 Port frame_err, output, 1, meaning one-cycle pulse when a stop bit samples low.
REQ-010 Port overrun, output, 1, meaning sticky flag: a byte was dropped because the pair was still held.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all timing below is relative to the synchronized signal rx_s.
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE: on rx_s == 0, the FSM SHALL go to START and clear the bit-timer.
REQ-015 START: at timer == CLKS_PER_BIT/2 - 1, rx_s SHALL be sampled; if 0, go to DATA with timer cleared and bit index 0; if 1 (glitch), return to IDLE without flags.
REQ-016 DATA: each time timer reaches CLKS_PER_BIT - 1, the FSM SHALL shift rx_s into the data register at the current index and restart the timer; after index 7, go to STOP.
REQ-017 STOP: at timer == CLKS_PER_BIT - 1, rx_s SHALL be sampled; if 1, commit the byte; if 0, pulse frame_err for one cycle and discard the byte; in both cases, return to IDLE.
REQ-018 The bit-timer width SHALL be $clog2(CLKS_PER_BIT), and the timer SHALL never wrap past CLKS_PER_BIT - 1.
REQ-019 A pair assembler with a 1-bit slot pointer (0 = old, 1 = new) SHALL route committed bytes.
REQ-020 A byte committed with slot 0 SHALL load the old-byte holding register and set slot to 1.
REQ-021 A byte committed with slot 1 SHALL update sharpe_old from holding, load sharpe_new, assert pair_valid on the next clk edge, and set slot to 0.
REQ-022 sharpe_old and sharpe_new SHALL be stable while pair_valid is 1.
REQ-023 pair_valid SHALL deassert on the edge after a cycle with pair_valid && pair_ready.
REQ-024 Holding register / slot 0 commits SHALL proceed while pair_valid is 1.
REQ-025 A slot-1 commit while pair_valid is 1 and pair_ready is 0 SHALL drop the byte, set overrun, return slot to 0, and leave outputs unchanged.
REQ-026 If the handshake completes in the same cycle as a slot-1 commit, the new pair SHALL load and pair_valid SHALL remain 1 with no overrun.
REQ-027 A frame error SHALL reset slot to 0 so the next good byte is treated as sharpe_old.
REQ-028 overrun SHALL clear only on reset.
REQ-029 Latency: pair_valid SHALL rise exactly 1 clk after the stop-bit sample cycle of the second byte, i.e. about 2 + 9.5*CLKS_PER_BIT + 1 clk after the rx falling edge of that byte.

Reset
REQ-030 rst_n low SHALL immediately force: FSM to IDLE, timer 0, bit index 0, slot 0, synchronizer flops 1, sharpe_old 0, sharpe_new 0, pair_valid 0, frame_err 0, overrun 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial byte; after release, the receiver SHALL wait for a fresh falling edge on rx_s.

Verification (CLKS_PER_BIT = 4)
REQ-032 Send bytes 0x7B then 0x80 with pair_ready=1 -> sharpe_old=0x7B, sharpe_new=0x80, pair_valid high for exactly 1 cycle, frame_err=0, overrun=0.
REQ-033 rx low for 1 clk only -> FSM returns to IDLE, no byte committed, all flags 0.
REQ-034 Send 0x55 with stop bit 0, then 0x10 and 0x20 -> frame_err pulses once; resulting pair is old=0x10, new=0x20.
REQ-035 pair_ready=0; send 0x01,0x02,0x03,0x04 -> outputs stay 0x01/0x02, overrun=1, pair_valid stays 1; raising pair_ready clears pair_valid next cycle.
REQ-036 Assert rst_n low during DATA bit 4 of the second byte, then release and send 0xAA,0xBB -> all outputs 0 during reset; pair old=0xAA, new=0xBB.
REQ-037 With pair_valid=1, assert pair_ready in the stop-sample cycle of a new second byte -> the new pair loads, pair_valid stays 1, overrun=0.
